// File: rtl/payload_crc_checker_pkg.sv
// Shared constants and state type for the payload CRC checker slice.
package core_params;

  localparam int PAYLOAD_WIDTH = 32;
  localparam int CRC_WIDTH     = 8;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = 8'h07;
  localparam logic [CRC_WIDTH-1:0] CRC_INIT = 8'h00;
  localparam int DATA_WIDTH    = PAYLOAD_WIDTH - CRC_WIDTH;
  localparam int CNT_WIDTH     = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {CRC_IDLE, CRC_CHECK, CRC_COMPARE} crc_state_t;

endpackage

// File: rtl/payload_crc_checker_if.sv
// Word-in / checked-data-out bundle between reciever_buffer, the checker and the sync stage.
interface payload_crc_checker_if;
  import core_params::*;

  logic                     send;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic [DATA_WIDTH-1:0]    data;
  logic                     valid;
  logic                     crc_err;
  logic                     overrun;
  logic                     busy;

  modport master (output send, payload, input data, valid, crc_err, overrun, busy);
  modport slave  (input send, payload, output data, valid, crc_err, overrun, busy);

endinterface

// File: rtl/payload_crc_checker_lfsr.sv
// Serial CRC LFSR: one data bit per enabled cycle, MSB first, reseeded by init.
module crc_lfsr_serial #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   POLY  = 8'h07,
  parameter logic [WIDTH-1:0]   INIT  = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= INIT;
    else if (init) crc <= INIT;
    else if (en)   crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/payload_crc_checker.sv
// Payload CRC checker: serial CRC over the data field, forwards good words, flags bad/dropped.
// Optional statistics counters are enabled by defining PAYLOAD_CRC_STATS_EN.
module payload_crc_checker
  import core_params::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  payload_crc_checker_if.slave  bus
`ifdef PAYLOAD_CRC_STATS_EN
  ,
  output logic [15:0]           err_count,
  output logic [15:0]           drop_count
`endif
);

  crc_state_t            state, next_state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CRC_WIDTH-1:0]  crc_field_q;
  logic [CRC_WIDTH-1:0]  crc;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic                  load, shift, compare, match, busy;

  assign busy     = (state != CRC_IDLE);
  assign bus.busy = busy;
  assign match    = (crc == crc_field_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CRC_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    compare    = 1'b0;
    unique case (state)
      CRC_IDLE: if (bus.send) begin
        load       = 1'b1;
        next_state = CRC_CHECK;
      end
      CRC_CHECK: begin
        shift = 1'b1;
        if (bit_cnt == '0) next_state = CRC_COMPARE;
      end
      CRC_COMPARE: begin
        compare    = 1'b1;
        next_state = CRC_IDLE;
      end
      default: next_state = CRC_IDLE;
    endcase
  end

  // Data field rotates rather than shifts, so it is intact again when COMPARE forwards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      crc_field_q <= '0;
      bit_cnt     <= '0;
    end else if (load) begin
      shift_q     <= bus.payload[PAYLOAD_WIDTH-1:CRC_WIDTH];
      crc_field_q <= bus.payload[CRC_WIDTH-1:0];
      bit_cnt     <= CNT_WIDTH'(DATA_WIDTH - 1);
    end else if (shift) begin
      shift_q <= {shift_q[DATA_WIDTH-2:0], shift_q[DATA_WIDTH-1]};
      if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_WIDTH'(1);
    end
  end

  crc_lfsr_serial #(
    .WIDTH (CRC_WIDTH),
    .POLY  (CRC_POLY),
    .INIT  (CRC_INIT)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (load),
    .en     (shift),
    .bit_in (shift_q[DATA_WIDTH-1]),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data    <= '0;
      bus.valid   <= 1'b0;
      bus.crc_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.valid   <= compare && match;
      bus.crc_err <= compare && !match;
      bus.overrun <= bus.send && busy;
      if (compare && match) bus.data <= shift_q;
    end
  end

`ifdef PAYLOAD_CRC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (bus.crc_err && err_count != 16'hFFFF)  err_count  <= err_count + 16'd1;
      if (bus.overrun && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_payload_crc_checker.sv
// Self-checking bench for payload_crc_checker: directed cases plus random words vs a division-based CRC model.
module tb_payload_crc_checker;
  import core_params::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  payload_crc_checker_if bus();

`ifdef PAYLOAD_CRC_STATS_EN
  logic [15:0] err_count, drop_count;
`endif

  payload_crc_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PAYLOAD_CRC_STATS_EN
    ,
    .err_count  (err_count),
    .drop_count (drop_count)
`endif
  );

  int tests = 0;
  int fails = 0;
  int n_valid = 0, n_err = 0, n_ovr = 0;
  logic [DATA_WIDTH-1:0] exp_data = '0;
  int exp_err = 0, exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as polynomial remainder of data*x^8 mod (x^8+x^2+x+1); valid because the seed is zero.
  function automatic logic [7:0] ref_crc(input logic [23:0] d);
    logic [31:0] m;
    m = {d, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (m[i]) m = m ^ (32'h107 << (i - 8));
    return m[7:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid)   n_valid++;
      if (bus.crc_err) n_err++;
      if (bus.overrun) n_ovr++;
      if (bus.valid || bus.crc_err)
        check("valid_err_exclusive", {31'b0, bus.valid & bus.crc_err}, 32'd0);
    end
  end

  // Drives one word at a negedge and checks the result timing around T+25.
  task automatic run_word(input string tag, input logic [23:0] d, input logic [7:0] c);
    logic good;
    good = (c == ref_crc(d));
    bus.send    = 1'b1;
    bus.payload = {d, c};
    @(negedge clk);
    bus.send = 1'b0;
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    repeat (24) @(negedge clk);
    check({tag, "_early"}, {30'b0, bus.valid, bus.crc_err}, 32'd0);
    @(negedge clk);
    if (good) exp_data = d;
    else      exp_err++;
    check({tag, "_valid"}, {31'b0, bus.valid}, {31'b0, good});
    check({tag, "_crc_err"}, {31'b0, bus.crc_err}, {31'b0, !good});
    check({tag, "_data"}, {8'b0, bus.data}, {8'b0, exp_data});
    @(negedge clk);
    check({tag, "_pulse_end"}, {30'b0, bus.valid, bus.crc_err}, 32'd0);
  endtask

  initial begin
    int bv, be, bo;
    logic [23:0] d, d2;
    bus.send    = 1'b0;
    bus.payload = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.valid, bus.crc_err, bus.overrun, bus.busy}, 32'd0);
    check("rst_data", {8'b0, bus.data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_word("t1_good", 24'h000001, 8'h07);
    run_word("t2_bad", 24'h000001, 8'h06);
    run_word("t3_zero", 24'h000000, 8'h00);

    // send held high for three cycles mid-check
    bv = n_valid; be = n_err; bo = n_ovr;
    d = 24'hABCDEF;
    bus.send = 1'b1; bus.payload = {d, ref_crc(d)};
    @(negedge clk);
    bus.send = 1'b0;
    repeat (5) @(negedge clk);
    bus.send = 1'b1; bus.payload = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    bus.send = 1'b0;
    repeat (30) @(negedge clk);
    exp_data = d; exp_drop += 3;
    check("ovr_count", n_ovr - bo, 32'd3);
    check("ovr_results", (n_valid - bv) + (n_err - be), 32'd1);
    check("ovr_data", {8'b0, bus.data}, {8'b0, exp_data});

    // spacing 26: both accepted; spacing 25: second dropped
    for (int gap = 26; gap >= 25; gap--) begin
      bv = n_valid; bo = n_ovr;
      d  = 24'($urandom);
      d2 = 24'($urandom);
      bus.send = 1'b1; bus.payload = {d, ref_crc(d)};
      @(negedge clk);
      bus.send = 1'b0;
      repeat (gap - 1) @(negedge clk);
      bus.send = 1'b1; bus.payload = {d2, ref_crc(d2)};
      @(negedge clk);
      bus.send = 1'b0;
      repeat (60) @(negedge clk);
      exp_data = (gap == 26) ? d2 : d;
      if (gap == 25) exp_drop++;
      check($sformatf("gap%0d_valids", gap), n_valid - bv, (gap == 26) ? 32'd2 : 32'd1);
      check($sformatf("gap%0d_ovr", gap), n_ovr - bo, (gap == 26) ? 32'd0 : 32'd1);
      check($sformatf("gap%0d_data", gap), {8'b0, bus.data}, {8'b0, exp_data});
    end

    for (int i = 0; i < 20; i++) begin
      logic [7:0] c;
      d = 24'($urandom);
      c = ref_crc(d);
      if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
      run_word($sformatf("rnd%0d", i), d, c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef PAYLOAD_CRC_STATS_EN
    check("stat_err", {16'b0, err_count}, exp_err);
    check("stat_drop", {16'b0, drop_count}, exp_drop);
`endif

    // reset mid-word aborts with no result
    d = 24'h123456;
    bus.send = 1'b1; bus.payload = {d, ref_crc(d)};
    @(negedge clk);
    bus.send = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {bus.valid, bus.crc_err, bus.overrun, bus.busy}, 32'd0);
    check("midrst_data", {8'b0, bus.data}, 32'd0);
    exp_data = '0; exp_err = 0; exp_drop = 0;
    bv = n_valid; be = n_err;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_result", (n_valid - bv) + (n_err - be), 32'd0);
`ifdef PAYLOAD_CRC_STATS_EN
    check("midrst_stats", {err_count, drop_count}, 32'd0);
`endif
    run_word("post_rst", 24'h5A5A5A, ref_crc(24'h5A5A5A));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
